// File: rtl/agc_timing_pkg.sv
// Shared timing constants for the AGC scaler chain.
// Stage numbers are 1-based (Fnn), so tap bit index is Fnn-1.
package agc_timing_pkg;

  localparam int PRESCALE_DEFAULT = 20;
  localparam int STAGES_DEFAULT   = 17;

  localparam int F05 = 5;
  localparam int F07 = 7;
  localparam int F08 = 8;
  localparam int F10 = 10;
  localparam int F14 = 14;

endpackage

// File: rtl/agc_prescaler.sv
// Divides CLOCK by PRESCALE; tick is high on the edge where pcnt wraps.
// SCAINH freezes pcnt and suppresses the tick, so nothing is lost on release.
module agc_prescaler
  import agc_timing_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic CLOCK,
  input  logic rst_,
  input  logic SCAINH,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;

  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      pcnt <= '0;
    end else if (!SCAINH) begin
      pcnt <= (pcnt == LAST) ? '0 : pcnt + PW'(1);
    end
  end

  assign tick = (pcnt == LAST) && !SCAINH;

endmodule

// File: rtl/agc_scaler.sv
// Binary scaler chain F01..Fnn with stage levels and one-CLOCK A/B phase pulses.
// Named taps assume STAGES >= 14.
module agc_scaler
  import agc_timing_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT,
  parameter int STAGES   = STAGES_DEFAULT
) (
  input  logic              CLOCK,
  input  logic              rst_,
  input  logic              SCAINH,
  output logic [STAGES-1:0] FS,
  output logic [STAGES-1:0] FA,
  output logic [STAGES-1:0] FB,
  output logic              FS01,
  output logic              FS10,
  output logic              F05A_,
  output logic              F05B_,
  output logic              F07B_,
  output logic              F10A_,
  output logic              F07A,
  output logic              F08B,
  output logic              F10B,
  output logic              F14B,
  output logic              SCATCK
);

  logic              tick;
  logic [STAGES-1:0] scnt;
  logic [STAGES-1:0] scnt_inc;

  agc_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .CLOCK  (CLOCK),
    .rst_   (rst_),
    .SCAINH (SCAINH),
    .tick   (tick)
  );

  assign scnt_inc = scnt + STAGES'(1);

  // Pulses are registered alongside scnt so a pulse and its new level share an edge.
  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      scnt   <= '0;
      FA     <= '0;
      FB     <= '0;
      SCATCK <= 1'b0;
    end else begin
      SCATCK <= tick;
      FA     <= tick ? (~scnt & scnt_inc) : '0;
      FB     <= tick ? (scnt & ~scnt_inc) : '0;
      if (tick) begin
        scnt <= scnt_inc;
      end
    end
  end

  assign FS    = scnt;
  assign FS01  = FS[0];
  assign FS10  = FS[F10-1];
  assign F05A_ = ~FA[F05-1];
  assign F05B_ = ~FB[F05-1];
  assign F07A  = FA[F07-1];
  assign F07B_ = ~FB[F07-1];
  assign F08B  = FB[F08-1];
  assign F10A_ = ~FA[F10-1];
  assign F10B  = FB[F10-1];
  assign F14B  = FB[F14-1];

endmodule

// File: tb/tb_agc_scaler.sv
// Bench for agc_scaler: a full-size instance and a short-chain instance (fast wrap),
// both compared every cycle against a count-based reference model.
module tb_agc_scaler;

  localparam int PM = 20;
  localparam int SM = 17;
  localparam int PS = 2;
  localparam int SS = 14;

  logic CLOCK = 1'b0;
  logic rst_  = 1'b0;
  logic SCAINH = 1'b0;

  always #5 CLOCK = ~CLOCK;

  logic [SM-1:0] fs_m, fa_m, fb_m;
  logic fs01_m, fs10_m, f05a_m, f05b_m, f07b_m, f10a_m, f07a_m, f08b_m, f10b_m, f14b_m, sck_m;
  logic [SS-1:0] fs_s, fa_s, fb_s;
  logic fs01_s, fs10_s, f05a_s, f05b_s, f07b_s, f10a_s, f07a_s, f08b_s, f10b_s, f14b_s, sck_s;

  agc_scaler #(.PRESCALE(PM), .STAGES(SM)) u_dut_main (
    .CLOCK(CLOCK), .rst_(rst_), .SCAINH(SCAINH),
    .FS(fs_m), .FA(fa_m), .FB(fb_m),
    .FS01(fs01_m), .FS10(fs10_m), .F05A_(f05a_m), .F05B_(f05b_m), .F07B_(f07b_m),
    .F10A_(f10a_m), .F07A(f07a_m), .F08B(f08b_m), .F10B(f10b_m), .F14B(f14b_m),
    .SCATCK(sck_m)
  );

  agc_scaler #(.PRESCALE(PS), .STAGES(SS)) u_dut_short (
    .CLOCK(CLOCK), .rst_(rst_), .SCAINH(SCAINH),
    .FS(fs_s), .FA(fa_s), .FB(fb_s),
    .FS01(fs01_s), .FS10(fs10_s), .F05A_(f05a_s), .F05B_(f05b_s), .F07B_(f07b_s),
    .F10A_(f10a_s), .F07A(f07a_s), .F08B(f08b_s), .F10B(f10b_s), .F14B(f14b_s),
    .SCATCK(sck_s)
  );

  int checks = 0;
  int failures = 0;
  int n_m = 0;
  int n_s = 0;
  bit adv = 1'b0;
  bit saw_wrap = 1'b0;
  bit saw_f10b = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // n = advancing CLOCK edges since reset; the stage count is just n/p.
  function automatic void ref_model(input int n, input int p, input int s, input bit a,
                                    output logic [31:0] fs, output logic [31:0] fa,
                                    output logic [31:0] fb, output logic tck);
    int k;
    k   = n / p;
    fs  = 32'(k % (1 << s));
    tck = a && (n > 0) && (n % p == 0);
    fa  = '0;
    fb  = '0;
    if (tck) begin
      for (int i = 0; i < s; i++) begin
        if (k % (1 << (i + 1)) == (1 << i)) fa[i] = 1'b1;
        if (k % (1 << (i + 1)) == 0)        fb[i] = 1'b1;
      end
    end
  endfunction

  function automatic logic [9:0] named_exp(input logic [31:0] fs, input logic [31:0] fa,
                                           input logic [31:0] fb);
    return {fs[0], fs[9], ~fa[4], ~fb[4], fa[6], ~fb[6], fb[7], ~fa[9], fb[9], fb[13]};
  endfunction

  task automatic compare_all();
    logic [31:0] fs, fa, fb;
    logic tck;
    ref_model(n_m, PM, SM, adv, fs, fa, fb, tck);
    check_eq("main_fs", 32'(fs_m), fs);
    check_eq("main_fa", 32'(fa_m), fa);
    check_eq("main_fb", 32'(fb_m), fb);
    check_eq("main_scatck", 32'(sck_m), 32'(tck));
    check_eq("main_named",
             32'({fs01_m, fs10_m, f05a_m, f05b_m, f07a_m, f07b_m, f08b_m, f10a_m, f10b_m, f14b_m}),
             32'(named_exp(fs, fa, fb)));
    ref_model(n_s, PS, SS, adv, fs, fa, fb, tck);
    check_eq("short_fs", 32'(fs_s), fs);
    check_eq("short_fa", 32'(fa_s), fa);
    check_eq("short_fb", 32'(fb_s), fb);
    check_eq("short_scatck", 32'(sck_s), 32'(tck));
    check_eq("short_named",
             32'({fs01_s, fs10_s, f05a_s, f05b_s, f07a_s, f07b_s, f08b_s, f10a_s, f10b_s, f14b_s}),
             32'(named_exp(fs, fa, fb)));
    if (fb_s == '1 && fs_s == '0) saw_wrap = 1'b1;
    if (f10b_m) saw_f10b = 1'b1;
  endtask

  task automatic tick_edge();
    @(posedge CLOCK);
    if (!SCAINH) begin
      n_m++;
      n_s++;
      adv = 1'b1;
    end else begin
      adv = 1'b0;
    end
    #1;
    compare_all();
  endtask

  initial begin
    #1000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [SM-1:0] fs_hold;
    int target;

    // Reset values while rst_ is held
    repeat (3) @(posedge CLOCK);
    #1;
    adv = 1'b0;
    compare_all();
    check_eq("rst_f05a_idle", 32'(f05a_m), 32'd1);
    @(negedge CLOCK);
    rst_ = 1'b1;

    // First tick lands on edge PRESCALE
    for (int e = 1; e <= 80; e++) begin
      tick_edge();
      if (e == 19) check_eq("e19_scatck", 32'(sck_m), 32'd0);
      if (e == 20) begin
        check_eq("e20_scatck", 32'(sck_m), 32'd1);
        check_eq("e20_fs01", 32'(fs01_m), 32'd1);
        check_eq("e20_fa", 32'(fa_m), 32'd1);
        check_eq("e20_fb", 32'(fb_m), 32'd0);
        check_eq("e20_fs_hi", 32'(fs_m[SM-1:1]), 32'd0);
        check_eq("e20_f05a_", 32'(f05a_m), 32'd1);
      end
      if (e == 80) begin
        check_eq("e80_fs", 32'(fs_m), 32'd4);
        check_eq("e80_fa", 32'(fa_m), 32'h4);
        check_eq("e80_fb", 32'(fb_m), 32'h3);
      end
    end

    // Run to the F05A pulse (tick 16, edge 320) and reset while it is in flight
    for (int e = 81; e <= 320; e++) tick_edge();
    check_eq("e320_f05a_", 32'(f05a_m), 32'd0);
    #1;
    rst_ = 1'b0;
    #1;
    n_m = 0;
    n_s = 0;
    adv = 1'b0;
    compare_all();
    check_eq("rst_mid_f05a_", 32'(f05a_m), 32'd1);
    @(negedge CLOCK);
    rst_ = 1'b1;

    // Park the prescaler at PRESCALE-1 and inhibit for 100 edges
    while (n_m % PM != PM - 1) tick_edge();
    fs_hold = fs_m;
    SCAINH = 1'b1;
    for (int e = 0; e < 100; e++) begin
      tick_edge();
      check_eq("inh_scatck", 32'(sck_m), 32'd0);
    end
    check_eq("inh_fs_frozen", 32'(fs_m), 32'(fs_hold));
    SCAINH = 1'b0;
    tick_edge();
    check_eq("release_tick", 32'(sck_m), 32'd1);
    check_eq("release_fs", 32'(fs_m), 32'(fs_hold) + 32'd1);

    // Random inhibit bursts until the short chain has wrapped
    target = PS * (1 << SS) + 8;
    for (int c = 0; c < 40000 && n_s < target; c++) begin
      SCAINH = ($urandom_range(31) == 0);
      tick_edge();
    end
    SCAINH = 1'b0;
    check_eq("run_budget", 32'(n_s >= target), 32'd1);
    check_eq("short_wrap_seen", 32'(saw_wrap), 32'd1);
    check_eq("main_f10b_seen", 32'(saw_f10b), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
